delay_sweep_ctrl: RTL and testbench



---
 rtl/delay_sweep_ctrl_if.sv | 28 ++
 rtl/delay_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_delay_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_sweep_ctrl_if.sv
// Handshake/config bundle between the register bank (master) and the
// delay sweep sequencer (slave), including the sequencer's outputs.
interface delay_sweep_ctrl_if #(
  parameter int SEL_W   = 8,
  parameter int DWELL_W = 16
);
  logic               start_i;
  logic               abort_i;
  logic [SEL_W-1:0]   sel_start_i;
  logic [SEL_W-1:0]   sel_stop_i;
  logic [SEL_W-1:0]   step_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [SEL_W-1:0]   sel_o;
  logic               valid_o;
  logic               busy_o;
  logic               step_strobe_o;
  logic               done_o;

  modport master (
    output start_i, abort_i, sel_start_i, sel_stop_i, step_i, dwell_i,
    input  sel_o, valid_o, busy_o, step_strobe_o, done_o
  );

  modport slave (
    input  start_i, abort_i, sel_start_i, sel_stop_i, step_i, dwell_i,
    output sel_o, valid_o, busy_o, step_strobe_o, done_o
  );
endinterface

// File: rtl/delay_sweep_ctrl.sv
// Delay-line tap sweep sequencer: steps sel_o from start to stop, blanking valid_o after each change.
// Optional macro DELAY_SWEEP_LOOP_EN: restart from the latched start value instead of finishing.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start, sel_o holds last value
// ST_SETTLE  | select just changed, valid_o blanked for SETTLE cycles
// ST_DWELL   | select stable, valid_o high for the latched dwell count
module delay_sweep_ctrl #(
  parameter int SEL_W   = 8,
  parameter int DWELL_W = 16,
  parameter int SETTLE  = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  delay_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL
  } state_e;

  localparam logic [DWELL_W-1:0] SETTLE_LD = DWELL_W'(SETTLE);
  localparam logic [DWELL_W-1:0] CNT_ONE   = DWELL_W'(1);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   stop_q, stop_d;
  logic [SEL_W-1:0]   step_q, step_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
`ifdef DELAY_SWEEP_LOOP_EN
  logic [SEL_W-1:0]   start_q, start_d;
`endif

  logic [SEL_W:0]     next_sum;
  logic               last_step;
  logic [DWELL_W-1:0] dwell_ld;

  // One extra bit catches wrap-around so 250+10 is never issued on an 8-bit select.
  assign next_sum  = {1'b0, sel_q} + {1'b0, step_q};
  assign last_step = (step_q == '0) || next_sum[SEL_W] || (next_sum[SEL_W-1:0] > stop_q);
  assign dwell_ld  = (bus.dwell_i == '0) ? CNT_ONE : bus.dwell_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    sel_d    = sel_q;
    stop_d   = stop_q;
    step_d   = step_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
`ifdef DELAY_SWEEP_LOOP_EN
    start_d  = start_q;
`endif

    if (bus.abort_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            stop_d   = bus.sel_stop_i;
            step_d   = bus.step_i;
            dwell_d  = dwell_ld;
            sel_d    = bus.sel_start_i;
`ifdef DELAY_SWEEP_LOOP_EN
            start_d  = bus.sel_start_i;
`endif
            strobe_d = 1'b1;
            cnt_d    = SETTLE_LD;
            valid_d  = 1'b0;
            busy_d   = 1'b1;
            state_d  = ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            cnt_d   = dwell_q;
            valid_d = 1'b1;
            state_d = ST_DWELL;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        ST_DWELL: begin
          if (cnt_q == CNT_ONE) begin
            valid_d = 1'b0;
            if (last_step) begin
              done_d = 1'b1;
`ifdef DELAY_SWEEP_LOOP_EN
              sel_d    = start_q;
              strobe_d = 1'b1;
              cnt_d    = SETTLE_LD;
              state_d  = ST_SETTLE;
`else
              busy_d  = 1'b0;
              state_d = ST_IDLE;
`endif
            end else begin
              sel_d    = next_sum[SEL_W-1:0];
              strobe_d = 1'b1;
              cnt_d    = SETTLE_LD;
              state_d  = ST_SETTLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dwell_q  <= '0;
      sel_q    <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef DELAY_SWEEP_LOOP_EN
      start_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      sel_q    <= sel_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
`ifdef DELAY_SWEEP_LOOP_EN
      start_q  <= start_d;
`endif
    end
  end

  assign bus.sel_o         = sel_q;
  assign bus.valid_o       = valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.step_strobe_o = strobe_q;
  assign bus.done_o        = done_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed self-checking bench for delay_sweep_ctrl (SETTLE=4); observed vector is {sel, valid, busy, strobe, done}.
module tb_delay_sweep_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  delay_sweep_ctrl_if #(.SEL_W(8), .DWELL_W(16)) bus ();

  delay_sweep_ctrl #(.SEL_W(8), .DWELL_W(16), .SETTLE(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] sample();
    return {bus.sel_o, bus.valid_o, bus.busy_o, bus.step_strobe_o, bus.done_o};
  endfunction

  task automatic set_cfg(input int s0, input int s1, input int st, input int dw);
    bus.sel_start_i = 8'(s0);
    bus.sel_stop_i  = 8'(s1);
    bus.step_i      = 8'(st);
    bus.dwell_i     = 16'(dw);
  endtask

  task automatic test_reset();
    logic [11:0] o;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    set_cfg(0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_asserted: actual %h, expected 000", o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    o = sample();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_released_idle: actual %h, expected 000", o);
    end
  endtask

  task automatic test_basic_sweep();
    logic [11:0] o, e;
    int idx, pos;
    @(negedge clk);
    set_cfg(10, 20, 5, 3);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      idx = (c - 1) / 7;
      pos = (c - 1) % 7;
      if (c <= 21)      e = {8'(10 + 5 * idx), pos >= 4, 1'b1, pos == 0, 1'b0};
      else if (c == 22) e = {8'd20, 4'b0001};
      else              e = {8'd20, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_sweep c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1) bus.start_i = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic [11:0] o, e;
    @(negedge clk);
    set_cfg(250, 255, 10, 2);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 6)      e = {8'd250, c >= 5, 1'b1, c == 1, 1'b0};
      else if (c == 7) e = {8'd250, 4'b0001};
      else             e = {8'd250, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1) bus.start_i = 1'b0;
    end
  endtask

  task automatic test_zero_dwell_step();
    logic [11:0] o, e;
    @(negedge clk);
    set_cfg(7, 100, 0, 0);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5)      e = {8'd7, c == 5, 1'b1, c == 1, 1'b0};
      else if (c == 6) e = {8'd7, 4'b0001};
      else             e = {8'd7, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_dwell_step c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1) bus.start_i = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [11:0] o, e;
    int idx, pos;
    @(negedge clk);
    set_cfg(10, 20, 5, 3);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      idx = (c - 1) / 7;
      pos = (c - 1) % 7;
      if (c <= 13) e = {8'(10 + 5 * idx), pos >= 4, 1'b1, pos == 0, 1'b0};
      else         e = {8'd15, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      case (c)
        1:  bus.start_i = 1'b0;
        3:  begin bus.start_i = 1'b1; set_cfg(99, 12, 1, 9); end
        4:  bus.start_i = 1'b0;
        13: bus.abort_i = 1'b1;
        14: bus.abort_i = 1'b0;
        15: begin bus.start_i = 1'b1; bus.abort_i = 1'b1; end
        16: begin bus.start_i = 1'b0; bus.abort_i = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [11:0] o, e;
    int idx, pos;
    @(negedge clk);
    set_cfg(10, 20, 5, 3);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 o = sample();
    n_checks++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_settle: actual %h, expected 000", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_cfg(30, 31, 1, 1);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      idx = (c - 1) / 5;
      pos = (c - 1) % 5;
      if (c <= 10)      e = {8'(30 + idx), pos == 4, 1'b1, pos == 0, 1'b0};
      else if (c == 11) e = {8'd31, 4'b0001};
      else              e = {8'd31, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL after_reset_sweep c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1) bus.start_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] o, e;
    @(negedge clk);
    set_cfg(5, 5, 1, 1);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c <= 5)       e = {8'd5, c == 5, 1'b1, c == 1, 1'b0};
      else if (c == 6)  e = {8'd5, 4'b0001};
      else if (c <= 11) e = {8'd40, c == 11, 1'b1, c == 7, 1'b0};
      else if (c == 12) e = {8'd40, 4'b0001};
      else              e = {8'd40, 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1) bus.start_i = 1'b0;
      if (c == 6) begin bus.start_i = 1'b1; set_cfg(40, 20, 1, 1); end
      if (c == 7) bus.start_i = 1'b0;
    end
  endtask

`ifdef DELAY_SWEEP_LOOP_EN
  task automatic test_loop();
    logic [11:0] o, e;
    int k;
    @(negedge clk);
    set_cfg(0, 2, 1, 1);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      k = (c - 1) % 15;
      if (c <= 32) e = {8'(k / 5), (k % 5) == 4, 1'b1, (k % 5) == 0, (c > 1) && (k == 0)};
      else         e = {8'(31 % 15 / 5), 4'b0000};
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loop c=%0d: actual sel=%0d vbsd=%b, expected sel=%0d vbsd=%b",
                 c, o[11:4], o[3:0], e[11:4], e[3:0]);
      end
      if (c == 1)  bus.start_i = 1'b0;
      if (c == 32) bus.abort_i = 1'b1;
      if (c == 33) bus.abort_i = 1'b0;
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifdef DELAY_SWEEP_LOOP_EN
    test_loop();
`else
    test_basic_sweep();
    test_overflow();
    test_zero_dwell_step();
    test_abort();
    test_reset_mid_settle();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
